// File: rtl/bd_line_decompressor.sv
// Expands one stored compressed cache line into eight 64-bit words, one word per cycle,
// then holds the result until the consumer takes it.
module bd_line_decompressor #(
    parameter int LINE_W = 644,
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LINE_W-1:0] in_line,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_addr,
    output logic              out_hit,
    output logic              out_err
);
    localparam int PAY_W = LINE_W - 8;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       cnt;
    logic [2:0]       enc;
    logic [PAY_W-1:0] payload;
    logic [63:0]      base, word;
    logic [7:0]       d8;
    logic [15:0]      d16;
    logic [31:0]      d32;
    logic             accept, last;

    assign accept    = (state == IDLE) && in_valid;
    assign last      = (state == EXPAND) && (cnt == 3'd7);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = EXPAND;
            EXPAND:  if (cnt == 3'd7) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word cnt of the captured line; deltas are packed after the 64-bit base.
    always_comb begin
        base = payload[63:0];
        d8   = payload[64 + 8*int'(cnt)  +: 8];
        d16  = payload[64 + 16*int'(cnt) +: 16];
        d32  = payload[64 + 32*int'(cnt) +: 32];
        word = '0;
        case (enc)
            3'b000:  word = payload[64*int'(cnt) +: 64];
            3'b001:  word = '0;
            3'b010:  word = base;
            3'b011:  word = base + {{56{d8[7]}},   d8};
            3'b100:  word = base + {{48{d16[15]}}, d16};
            3'b101:  word = base + {{32{d32[31]}}, d32};
            default: word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            enc      <= '0;
            payload  <= '0;
            out_data <= '0;
            out_addr <= '0;
            out_hit  <= 1'b0;
            out_err  <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            enc      <= in_line[LINE_W-6 -: 3];
            payload  <= in_line[PAY_W-1:0];
            out_addr <= in_line[LINE_W-2 -: 4];
            out_hit  <= in_line[LINE_W-1];
            out_err  <= 1'b0;
        end else if (state == EXPAND) begin
            out_data[64*int'(cnt) +: 64] <= word;
            cnt <= cnt + 3'd1;
            // Reserved encodings still run the full 8 cycles and flag only on completion.
            if (last) out_err <= (enc[2:1] == 2'b11);
        end
    end
endmodule

// File: tb/tb_bd_line_decompressor.sv
// Directed bench: cycle-level reference model of the line protocol plus literal spot checks.
module tb_bd_line_decompressor;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [643:0] in_line;
    logic [511:0] out_data;
    logic [3:0]   out_addr;
    logic         out_hit, out_err;

    int n_cmp = 0;
    int n_bad = 0;

    bd_line_decompressor dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_line(in_line), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_hit(out_hit), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Expected expansion of a whole line, computed word by word from the encoding rules.
    function automatic logic [511:0] decode(input logic [643:0] l);
        logic [635:0]       p;
        logic [635:0]       sh;
        logic [2:0]         e;
        logic [63:0]        b;
        logic signed [63:0] d;
        logic [511:0]       r;
        int                 k;
        p = l[635:0];
        e = l[638:636];
        b = p[63:0];
        r = '0;
        k = (e == 3'd3) ? 8 : (e == 3'd4) ? 16 : 32;
        for (int i = 0; i < 8; i++) begin
            case (e)
                3'd0: r[64*i +: 64] = p[64*i +: 64];
                3'd2: r[64*i +: 64] = b;
                3'd3, 3'd4, 3'd5: begin
                    sh = p >> (64 + k*i);
                    d  = sh[63:0];
                    d  = d <<< (64 - k);
                    d  = d >>> (64 - k);
                    r[64*i +: 64] = b + d;
                end
                default: r[64*i +: 64] = '0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [643:0] mk(input logic hit, input logic [3:0] addr,
                                        input logic [2:0] enc, input logic [635:0] p);
        return {hit, addr, enc, p};
    endfunction

    // Reference model: 0 idle, 1 expanding (m_left cycles to go), 2 holding result.
    int           m_state = 0;
    int           m_left  = 0;
    logic [511:0] m_data  = '0;
    logic [3:0]   m_addr  = '0;
    logic         m_hit   = 1'b0;
    logic         m_err   = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_left = 0; m_data = '0; m_addr = '0; m_hit = 1'b0; m_err = 1'b0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_data  = decode(in_line);
                    m_addr  = in_line[642:639];
                    m_hit   = in_line[643];
                    m_err   = (in_line[638:636] >= 3'd6);
                    m_left  = 8;
                    m_state = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_state = 2;
                end
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ready", 512'(in_ready), 512'(1'b1));
            chk("rst_outs", {out_data, out_addr, out_hit, out_err, out_valid}, '0);
        end else begin
            chk("mon_ready", 512'(in_ready), 512'(m_state == 0));
            chk("mon_valid", 512'(out_valid), 512'(m_state == 2));
            if (m_state == 2) begin
                chk("mon_data", out_data, m_data);
                chk("mon_tag", 512'({out_addr, out_hit, out_err}), 512'({m_addr, m_hit, m_err}));
            end
        end
    end

    task automatic present(input logic [643:0] l);
        in_line  = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) chk("timeout", 512'(out_valid), 512'(1'b1));
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    logic [635:0] p;
    logic [511:0] snap;
    int           lat;

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; in_line = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("ready_after_reset", 512'(in_ready), 512'(1'b1));
        @(posedge clk); #1;

        // all-zero encoding
        present(mk(1'b1, 4'hA, 3'b001, '0));
        wait_done(lat);
        chk("zero_lat", 512'(lat), 512'(8));
        chk("zero_data", out_data, '0);
        chk("zero_tag", 512'({out_addr, out_hit, out_err}), 512'({4'hA, 1'b1, 1'b0}));
        handoff();

        // base + 8-bit deltas
        p = '0; p[63:0] = 64'h1000; p[127:64] = 64'h0000_0000_807F_FF01;
        present(mk(1'b0, 4'h2, 3'b011, p));
        wait_done(lat);
        chk("d1_w0", 512'(out_data[63:0]),    512'(64'h1001));
        chk("d1_w1", 512'(out_data[127:64]),  512'(64'h0FFF));
        chk("d1_w2", 512'(out_data[191:128]), 512'(64'h107F));
        chk("d1_w3", 512'(out_data[255:192]), 512'(64'h0F80));
        chk("d1_w7", 512'(out_data[511:448]), 512'(64'h1000));
        handoff();

        // base + 32-bit delta wrapping past 2^64
        p = '0; p[63:0] = 64'hFFFF_FFFF_FFFF_FFFF; p[95:64] = 32'h2;
        present(mk(1'b1, 4'h7, 3'b101, p));
        wait_done(lat);
        chk("wrap_w0", 512'(out_data[63:0]), 512'(64'h1));
        chk("wrap_w1", 512'(out_data[127:64]), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("wrap_err", 512'(out_err), 512'(1'b0));
        handoff();

        // uncompressed, repeated and 16-bit delta lines, checked by the model
        for (int i = 0; i < 20; i++) p[32*i +: 32] = $urandom;
        present(mk(1'b0, 4'h1, 3'b000, p)); wait_done(lat); handoff();
        present(mk(1'b1, 4'h4, 3'b010, p)); wait_done(lat);
        chk("rep_w5", 512'(out_data[383:320]), 512'(p[63:0]));
        handoff();
        present(mk(1'b1, 4'hC, 3'b100, p)); wait_done(lat); handoff();

        // reserved encoding
        present(mk(1'b1, 4'hE, 3'b111, p));
        wait_done(lat);
        chk("rsv_lat", 512'(lat), 512'(8));
        chk("rsv_data", out_data, '0);
        chk("rsv_err", 512'(out_err), 512'(1'b1));
        handoff();

        // backpressure with a competing line on the input
        present(mk(1'b0, 4'h3, 3'b010, p));
        wait_done(lat);
        snap = out_data;
        in_line = mk(1'b1, 4'h5, 3'b000, ~p);
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold", out_data, snap);
            chk("bp_ready", 512'({in_ready, out_valid}), 512'(2'b01));
        end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        chk("bp_handoff", 512'({in_ready, out_valid}), 512'(2'b10));
        @(posedge clk); #1 in_valid = 1'b0;
        chk("bp_accept", 512'(in_ready), 512'(1'b0));
        wait_done(lat);
        chk("bp_lat", 512'(lat), 512'(8));
        chk("bp_addr", 512'(out_addr), 512'(4'h5));
        handoff();

        // reset in the middle of expansion
        p = '0; p[63:0] = 64'h50; p[71:64] = 8'hF0;
        present(mk(1'b1, 4'h9, 3'b011, p));
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("mid_rst_outs", {out_data, out_addr, out_hit, out_err, out_valid}, '0);
        chk("mid_rst_ready", 512'(in_ready), 512'(1'b1));
        #3 reset = 1'b1;
        #1 chk("mid_rel_ready", 512'(in_ready), 512'(1'b1));
        @(posedge clk); #1;
        present(mk(1'b0, 4'h6, 3'b011, p));
        wait_done(lat);
        chk("post_rst_lat", 512'(lat), 512'(8));
        chk("post_rst_w0", 512'(out_data[63:0]), 512'(64'h40));
        handoff();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
